shuttle_run_scheduler: RTL

//  Sequences the IR-gated motor shuttle FSM through a commanded number of full forward/back cycles.
//  Per cycle: pulses the shuttle start, watches the shuttle enable/direction, then enforces a dwell gap.
//  A watchdog timeout guards every cycle, and an abort path stops the motor safely.

---
 rtl/shuttle_run_scheduler_if.sv | 25 ++
 rtl/shuttle_run_scheduler.sv | 138 +++++++++++++
 2 files changed

// File: rtl/shuttle_run_scheduler_if.sv
// Command and shuttle-side signals of the shuttle run scheduler.
// master = host/shuttle environment, slave = the scheduler itself.
interface shuttle_run_scheduler_if #(
  parameter int CYC_W = 8
);
  // cmd_valid/cmd_ready: a command transfers on a clock where both are high.
  // cmd_ready is high only while idle; a valid seen while not ready is dropped, not held.
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CYC_W-1:0] cmd_cycles;
  logic             sh_busy;
  logic             sh_dir;
  logic             sh_start;
  logic             sh_stop;

  modport master (
    output cmd_valid, cmd_cycles, sh_busy, sh_dir,
    input  cmd_ready, sh_start, sh_stop
  );

  modport slave (
    input  cmd_valid, cmd_cycles, sh_busy, sh_dir,
    output cmd_ready, sh_start, sh_stop
  );
endinterface

// File: rtl/shuttle_run_scheduler.sv
// Runs a commanded number of forward/back shuttle cycles with dwell gaps between them,
// a per-cycle watchdog, an abort path that stops the motor, and a latched fault state.
module shuttle_run_scheduler #(
  parameter int CYC_W       = 8,
  parameter int DWELL_CYC   = 1000,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int TMR_W       = 26
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  shuttle_run_scheduler_if.slave bus,
  input  logic                   abort,
  input  logic                   fault_clr,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic                   fault,
  output logic [CYC_W-1:0]       cycles_done,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_DWELL     = 3'd4,
    S_ABORTING  = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CYC_W-1:0] target_q, target_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;
  logic [CYC_W-1:0] cyc_inc;
  logic             saw_bw_q, saw_bw_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             timeout, dwell_end, bw_seen;

  assign timeout   = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
  assign dwell_end = (timer_q == TMR_W'(DWELL_CYC - 1));
  // A backward phase seen on the very clock busy drops still completes the cycle.
  assign bw_seen   = saw_bw_q | ~bus.sh_dir;
  assign cyc_inc   = (cycles_q == '1) ? cycles_q : cycles_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cycles_d  = cycles_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          target_d = bus.cmd_cycles;
          cycles_d = '0;
          if (bus.cmd_cycles == '0) done_d = 1'b1;
          else state_d = S_START;
        end
      end
      S_START: state_d = abort ? S_ABORTING : S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (timeout) state_d = S_FAULT;
        else if (abort) state_d = S_ABORTING;
        else if (bus.sh_busy) state_d = S_RUN;
      end
      S_RUN: begin
        // Faults outrank abort, which outranks normal completion.
        if (timeout || (!bus.sh_busy && !bw_seen)) state_d = S_FAULT;
        else if (abort) state_d = S_ABORTING;
        else if (!bus.sh_busy) begin
          cycles_d = cyc_inc;
          if (cyc_inc == target_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DWELL;
          end
        end
      end
      S_DWELL: begin
        if (abort) state_d = S_ABORTING;
        else if (dwell_end) state_d = S_START;
      end
      S_ABORTING: begin
        if (!bus.sh_busy) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end
      end
      S_FAULT: if (fault_clr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    saw_bw_d = saw_bw_q;
    if (state_q == S_RUN && !bus.sh_dir) saw_bw_d = 1'b1;
    if (state_d == S_RUN && state_q != S_RUN) saw_bw_d = 1'b0;

    timer_d = timer_q;
    if (state_d != state_q) timer_d = '0;
    else if ((state_q == S_WAIT_BUSY || state_q == S_RUN || state_q == S_DWELL)
             && timer_q != '1) timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      target_q  <= '0;
      cycles_q  <= '0;
      saw_bw_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      target_q  <= target_d;
      cycles_q  <= cycles_d;
      saw_bw_q  <= saw_bw_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Every output is a register or a pure decode of state.
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.sh_start  = (state_q == S_START);
  assign bus.sh_stop   = (state_q == S_ABORTING) || (state_q == S_FAULT);
  assign busy          = (state_q != S_IDLE);
  assign fault         = (state_q == S_FAULT);
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign cycles_done   = cycles_q;
  assign dbg_state     = state_q;

endmodule
